// File: rtl/mem_resp_pkg.sv
// Shared types and default sizing for the data-memory responder.
package mem_resp_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_resp_if.sv
// CPU data-memory port: request fields from the core, completion back to it.
interface mem_resp_if
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_err;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, mem_err
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready, mem_err
  );

endinterface

// File: rtl/mem_resp_ram.sv
// DEPTH x DATA_W storage: frontdoor + backdoor write ports, one async read port.
// Kept apart from the FSM so a technology RAM can be dropped in.
module mem_resp_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              fd_we_i,
  input  logic [ADDR_W-1:0] fd_addr_i,
  input  logic [DATA_W-1:0] fd_wdata_i,
  input  logic              bd_we_i,
  input  logic [ADDR_W-1:0] bd_addr_i,
  input  logic [DATA_W-1:0] bd_wdata_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              fd_ok, bd_ok, rd_ok;

  assign fd_ok = fd_we_i && ({1'b0, fd_addr_i} < DEPTH_C);
  assign bd_ok = bd_we_i && ({1'b0, bd_addr_i} < DEPTH_C);
  assign rd_ok = rd_en_i && ({1'b0, rd_addr_i} < DEPTH_C);

  // Frontdoor is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (bd_ok) mem_q[bd_addr_i[IDX_W-1:0]] <= bd_wdata_i;
    if (fd_ok) mem_q[fd_addr_i[IDX_W-1:0]] <= fd_wdata_i;
  end

  assign rd_data_o = rd_ok ? mem_q[rd_addr_i[IDX_W-1:0]] : '0;

endmodule

// File: rtl/mem_resp_unit.sv
// Parametrised memory responder with LATENCY-cycle access and range errors.
// Optional MEM_STATS_EN adds saturating rd_count/wr_count statistics.
module mem_resp_unit
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = 256,
  parameter int LATENCY = DEF_LATENCY,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  mem_resp_if.slave         bus,
  output logic              busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
`ifdef MEM_STATS_EN
  ,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
`endif
);

  localparam int               LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY - 1);
  localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  logic              fd_we, rd_en;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          we_d    = bus.mem_we;
          addr_d  = bus.mem_addr;
          wdata_d = bus.mem_wdata;
          cnt_d   = LAT_INIT;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - LAT_W'(1);
        if (cnt_d == '0) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Completion flags are registered so they line up exactly with RESP.
    ready_d = (state_d == RESP);
    err_d   = (state_d == RESP) && ({1'b0, addr_d} >= DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // A reset landing on the RESP edge must not let the write commit.
  assign fd_we = (state_q == RESP) && we_q && !rst;
  assign rd_en = (state_q == RESP) && !we_q;

  mem_resp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk        (clk),
    .fd_we_i    (fd_we),
    .fd_addr_i  (addr_q),
    .fd_wdata_i (wdata_q),
    .bd_we_i    (ld_en),
    .bd_addr_i  (ld_addr),
    .bd_wdata_i (ld_data),
    .rd_en_i    (rd_en),
    .rd_addr_i  (addr_q),
    .rd_data_o  (ram_rdata)
  );

  assign bus.mem_rdata = ram_rdata;
  assign bus.mem_ready = ready_q;
  assign bus.mem_err   = err_q;
  assign busy          = (state_q != IDLE);

`ifdef MEM_STATS_EN
  logic [CNT_W-1:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (state_q == RESP) begin
      if (we_q) begin
        if (!(&wr_cnt_q)) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end else begin
        if (!(&rd_cnt_q)) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_mem_resp_unit.sv
// Directed bench: three responders (LAT1/D256, LAT4/D128, LAT3/D256) side by side.
module tb_mem_resp_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      rst, req, we, ld_en;
  logic [2:0][7:0] addr, wdata, ld_addr, ld_data;
  logic [2:0]      rdy, err, busy;
  logic [2:0][7:0] rdata;
`ifdef MEM_STATS_EN
  logic [2:0][15:0] rdc, wrc;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    mem_resp_if #(.ADDR_W(8), .DATA_W(8)) ifc ();
    assign ifc.mem_req   = req[i];
    assign ifc.mem_we    = we[i];
    assign ifc.mem_addr  = addr[i];
    assign ifc.mem_wdata = wdata[i];
    assign rdy[i]        = ifc.mem_ready;
    assign err[i]        = ifc.mem_err;
    assign rdata[i]      = ifc.mem_rdata;

    mem_resp_unit #(
      .ADDR_W  (8),
      .DATA_W  (8),
      .DEPTH   ((i == 1) ? 128 : 256),
      .LATENCY ((i == 0) ? 1 : (i == 1) ? 4 : 3),
      .CNT_W   (16)
    ) u_dut (
      .clk      (clk),
      .rst      (rst[i]),
      .bus      (ifc),
      .busy     (busy[i]),
      .ld_en    (ld_en[i]),
      .ld_addr  (ld_addr[i]),
      .ld_data  (ld_data[i])
`ifdef MEM_STATS_EN
      ,
      .rd_count (rdc[i]),
      .wr_count (wrc[i])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic ld(input int k, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en[k] = 1'b1; ld_addr[k] = a; ld_data[k] = d;
    @(negedge clk);
    ld_en[k] = 1'b0;
  endtask

  // One frontdoor access; optional backdoor write issued in the RESP cycle.
  task automatic acc(input int k, input bit w, input logic [7:0] a, input logic [7:0] d,
                     input int lat, input bit tog, input bit bd,
                     input logic [7:0] ba, input logic [7:0] bdat,
                     output logic [7:0] rd, output logic e);
    int n;
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("busy_after_cap", busy[k], 1);
      if (tog && !rdy[k]) begin addr[k] = ~a; wdata[k] = ~d; we[k] = ~w; end
    end while (!rdy[k] && n < 20);
    chk("latency", n, lat);
    rd = rdata[k];
    e  = err[k];
    req[k] = 1'b0; we[k] = 1'b0;
    if (bd) begin ld_en[k] = 1'b1; ld_addr[k] = ba; ld_data[k] = bdat; end
    @(negedge clk);
    ld_en[k] = 1'b0;
    chk("busy_after_resp", busy[k], 0);
    chk("ready_one_cycle", rdy[k], 0);
  endtask

  task automatic rd_chk(input int k, input logic [7:0] a, input int lat,
                        input logic [7:0] exp, input string tag);
    logic [7:0] r; logic e;
    acc(k, 1'b0, a, 8'h00, lat, 1'b0, 1'b0, 8'h00, 8'h00, r, e);
    chk(tag, r, exp);
    chk({tag, "_err"}, e, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic       e;
    logic       saw;
    req = '0; we = '0; addr = '0; wdata = '0;
    ld_en = '0; ld_addr = '0; ld_data = '0; rst = '1;
    repeat (3) @(negedge clk);
    rst = '0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_ctl", {rdy, busy, err}, 0);
      chk("idle_rdata", rdata, 0);
    end

    // LATENCY=1 read of preloaded word
    ld(0, 8'h10, 8'hA5);
    rd_chk(0, 8'h10, 1, 8'hA5, "l1_rd");

    // LATENCY=4 write then read, fields toggled while busy
    acc(1, 1'b1, 8'h20, 8'h3C, 4, 1'b0, 1'b0, 8'h00, 8'h00, r, e);
    chk("l4_wr_rdata", r, 0);
    chk("l4_wr_err", e, 0);
    acc(1, 1'b0, 8'h20, 8'h00, 4, 1'b1, 1'b0, 8'h00, 8'h00, r, e);
    chk("l4_rd_tog", r, 8'h3C);
    chk("l4_rd_tog_err", e, 0);

    // DEPTH=128 out-of-range: 0x90 would alias 0x10 if unchecked
    ld(1, 8'h10, 8'h5A);
    acc(1, 1'b0, 8'h90, 8'h00, 4, 1'b0, 1'b0, 8'h00, 8'h00, r, e);
    chk("oor_rd_err", e, 1);
    chk("oor_rd_data", r, 0);
    acc(1, 1'b1, 8'h90, 8'hFF, 4, 1'b0, 1'b0, 8'h00, 8'h00, r, e);
    chk("oor_wr_err", e, 1);
    rd_chk(1, 8'h10, 4, 8'h5A, "oor_wr_dropped");
    ld(1, 8'h90, 8'h77);
    rd_chk(1, 8'h10, 4, 8'h5A, "oor_ld_dropped");

    // Same-cycle frontdoor/backdoor conflicts
    acc(0, 1'b1, 8'h05, 8'h11, 1, 1'b0, 1'b1, 8'h05, 8'h22, r, e);
    rd_chk(0, 8'h05, 1, 8'h11, "conf_same_addr");
    acc(0, 1'b1, 8'h08, 8'h77, 1, 1'b0, 1'b1, 8'h06, 8'h33, r, e);
    rd_chk(0, 8'h06, 1, 8'h33, "conf_ld_other");
    rd_chk(0, 8'h08, 1, 8'h77, "conf_fd_other");
    acc(0, 1'b0, 8'h06, 8'h00, 1, 1'b0, 1'b1, 8'h06, 8'h44, r, e);
    chk("rd_no_bypass", r, 8'h33);
    rd_chk(0, 8'h06, 1, 8'h44, "rd_after_ld");

    // Reset while in WAIT discards the pending write
    ld(2, 8'h07, 8'h5A);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 8'h07; wdata[2] = 8'h99;
    @(posedge clk);
    @(negedge clk);
    chk("rst_wait_busy_pre", busy[2], 1);
    @(negedge clk);
    rst[2] = 1'b1; req[2] = 1'b0; we[2] = 1'b0;
    saw = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      saw |= rdy[2];
    end
    chk("rst_wait_nordy", saw, 0);
    chk("rst_wait_busy", busy[2], 0);
    rst[2] = 1'b0;
    rd_chk(2, 8'h07, 3, 8'h5A, "rst_wait_mem");

    acc(2, 1'b1, 8'h30, 8'h01, 3, 1'b0, 1'b0, 8'h00, 8'h00, r, e);
    acc(2, 1'b1, 8'h31, 8'h02, 3, 1'b0, 1'b0, 8'h00, 8'h00, r, e);
    rd_chk(2, 8'h30, 3, 8'h01, "l3_rd30");
    rd_chk(2, 8'h31, 3, 8'h02, "l3_rd31");
`ifdef MEM_STATS_EN
    chk("rd_count", rdc[2], 3);
    chk("wr_count", wrc[2], 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
